// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit
//   Instruction-fetch stage. Holds the word-addressed program counter,
//   captures the fetched instruction into the IF/ID register and computes
//   the branch target from the ID-stage offset (already in words, added
//   unscaled). Stall freezes the stage; a taken branch/jump from a valid
//   IF/ID entry redirects the PC and inserts exactly one bubble.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous active-high reset
//   stall          hold pc, IF/ID and redirect_count
//   branch_taken   ID branch decision for the IF/ID instruction
//   jump           ID unconditional jump for the IF/ID instruction
//   branch_offset  signed word offset relative to id_pc_plus1
//   jump_target    absolute jump address (words)
//   instr_in       instruction memory data for address pc
//   pc             current fetch address
//   id_instr       IF/ID instruction (0 = NOP)
//   id_pc_plus1    IF/ID address of the next sequential instruction
//   id_valid       IF/ID holds a real instruction
//   branch_target  id_pc_plus1 + branch_offset
//   redirect_count saturating count of taken redirects
module fetch_pc_unit #(
  parameter int unsigned          PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic                jump,
  input  logic [PC_WIDTH-1:0] branch_offset,
  input  logic [PC_WIDTH-1:0] jump_target,
  input  logic [31:0]         instr_in,
  output logic [PC_WIDTH-1:0] pc,
  output logic [31:0]         id_instr,
  output logic [PC_WIDTH-1:0] id_pc_plus1,
  output logic                id_valid,
  output logic [PC_WIDTH-1:0] branch_target,
  output logic [15:0]         redirect_count
);

  logic                redirect;
  logic [PC_WIDTH-1:0] redirect_pc;
  logic [PC_WIDTH-1:0] pc_plus1;

  // Gating on id_valid means a bubble can never redirect, even if ID
  // still drives stale branch/jump decisions.
  always_comb begin
    branch_target = id_pc_plus1 + branch_offset;
    redirect      = id_valid & (jump | branch_taken);
    redirect_pc   = jump ? jump_target : branch_target;
    pc_plus1      = pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc             <= RESET_PC;
      id_instr       <= '0;
      id_pc_plus1    <= '0;
      id_valid       <= 1'b0;
      redirect_count <= '0;
    end else if (stall) begin
      // hold everything; ID re-asserts branch/jump after the stall
    end else if (redirect) begin
      pc          <= redirect_pc;
      id_instr    <= '0;
      id_pc_plus1 <= '0;
      id_valid    <= 1'b0;
      if (redirect_count != 16'hFFFF)
        redirect_count <= redirect_count + 16'd1;
    end else begin
      pc          <= pc_plus1;
      id_instr    <= instr_in;
      id_pc_plus1 <= pc_plus1;
      id_valid    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic        jump;
  logic [31:0] branch_offset;
  logic [31:0] jump_target;
  logic [31:0] instr_in, instr_in2;

  logic [31:0] pc, id_instr, id_pc_plus1, branch_target;
  logic        id_valid;
  logic [15:0] redirect_count;

  logic [31:0] pc2, id_instr2, id_pc_plus1_2, branch_target2;
  logic        id_valid2;
  logic [15:0] redirect_count2;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  // instruction memory model: mem[a] = 0x11 * (a + 1)
  always_comb instr_in  = 32'h11 * (pc + 32'd1);
  always_comb instr_in2 = 32'h11 * (pc2 + 32'd1);

  fetch_pc_unit #(.PC_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .jump(jump), .branch_offset(branch_offset), .jump_target(jump_target),
    .instr_in(instr_in), .pc(pc), .id_instr(id_instr),
    .id_pc_plus1(id_pc_plus1), .id_valid(id_valid),
    .branch_target(branch_target), .redirect_count(redirect_count)
  );

  fetch_pc_unit #(.PC_WIDTH(32), .RESET_PC(32'hFFFF_FFFE)) dut2 (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .jump(jump), .branch_offset(branch_offset), .jump_target(jump_target),
    .instr_in(instr_in2), .pc(pc2), .id_instr(id_instr2),
    .id_pc_plus1(id_pc_plus1_2), .id_valid(id_valid2),
    .branch_target(branch_target2), .redirect_count(redirect_count2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    branch_offset = '0; jump_target = '0;
    step(); step();
    reset = 1'b0;
    tests_run++;
    if (pc !== 32'h0 || id_valid !== 1'b0 || id_instr !== 32'h0 ||
        id_pc_plus1 !== 32'h0 || redirect_count !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_state: pc=%h valid=%b instr=%h p1=%h cnt=%h, want 0/0/0/0/0",
               pc, id_valid, id_instr, id_pc_plus1, redirect_count);
    end
  endtask

  task automatic test_fetch();
    for (int i = 1; i <= 4; i++) begin
      step();
      tests_run++;
      if (pc !== 32'(i) || id_instr !== 32'h11 * 32'(i) ||
          id_pc_plus1 !== 32'(i) || id_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL fetch_%0d: pc=%h instr=%h p1=%h valid=%b, want %h/%h/%h/1",
                 i, pc, id_instr, id_pc_plus1, id_valid, i, 32'h11 * i, i);
      end
    end
  endtask

  task automatic test_branch();
    step();  // pc=5, id_pc_plus1=5
    branch_offset = 32'hFFFF_FFFD;
    branch_taken  = 1'b1;
    #1;
    tests_run++;
    if (id_pc_plus1 !== 32'd5 || branch_target !== 32'd2) begin
      tests_failed++;
      $display("FAIL branch_target: p1=%h target=%h, want 5/2", id_pc_plus1, branch_target);
    end
    step();
    branch_taken = 1'b0;
    tests_run++;
    if (pc !== 32'd2 || id_valid !== 1'b0 || id_instr !== 32'h0 ||
        id_pc_plus1 !== 32'h0 || redirect_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL branch_redirect: pc=%h valid=%b instr=%h p1=%h cnt=%h, want 2/0/0/0/1",
               pc, id_valid, id_instr, id_pc_plus1, redirect_count);
    end
    step();
    tests_run++;
    if (pc !== 32'd3 || id_instr !== 32'h33 || id_valid !== 1'b1 || id_pc_plus1 !== 32'd3) begin
      tests_failed++;
      $display("FAIL branch_refill: pc=%h instr=%h valid=%b p1=%h, want 3/33/1/3",
               pc, id_instr, id_valid, id_pc_plus1);
    end
  endtask

  task automatic test_jump();
    jump = 1'b1; branch_taken = 1'b1; jump_target = 32'h40;
    step();
    jump = 1'b0;
    tests_run++;
    if (pc !== 32'h40 || id_valid !== 1'b0 || redirect_count !== 16'd2) begin
      tests_failed++;
      $display("FAIL jump_wins: pc=%h valid=%b cnt=%h, want 40/0/2", pc, id_valid, redirect_count);
    end
    // branch_taken still high while IF/ID is a bubble: must not redirect
    step();
    branch_taken = 1'b0;
    tests_run++;
    if (pc !== 32'h41 || id_valid !== 1'b1 || id_instr !== 32'h451 || redirect_count !== 16'd2) begin
      tests_failed++;
      $display("FAIL bubble_no_redirect: pc=%h valid=%b instr=%h cnt=%h, want 41/1/451/2",
               pc, id_valid, id_instr, redirect_count);
    end
  endtask

  task automatic test_stall();
    branch_offset = 32'd3;
    branch_taken  = 1'b1;
    stall         = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (pc !== 32'h41 || id_pc_plus1 !== 32'h41 || id_instr !== 32'h451 ||
          id_valid !== 1'b1 || redirect_count !== 16'd2) begin
        tests_failed++;
        $display("FAIL stall_hold_%0d: pc=%h p1=%h instr=%h valid=%b cnt=%h, want 41/41/451/1/2",
                 i, pc, id_pc_plus1, id_instr, id_valid, redirect_count);
      end
    end
    stall = 1'b0;
    step();
    branch_taken = 1'b0;
    tests_run++;
    if (pc !== 32'h44 || id_valid !== 1'b0 || redirect_count !== 16'd3) begin
      tests_failed++;
      $display("FAIL stall_release_redirect: pc=%h valid=%b cnt=%h, want 44/0/3",
               pc, id_valid, redirect_count);
    end
  endtask

  task automatic test_reset_override();
    step();  // valid IF/ID at pc 0x44
    reset = 1'b1; stall = 1'b1; jump = 1'b1; branch_taken = 1'b1; jump_target = 32'h80;
    step();
    reset = 1'b0; stall = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    tests_run++;
    if (pc !== 32'h0 || id_valid !== 1'b0 || id_instr !== 32'h0 ||
        id_pc_plus1 !== 32'h0 || redirect_count !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_override: pc=%h valid=%b instr=%h p1=%h cnt=%h, want 0/0/0/0/0",
               pc, id_valid, id_instr, id_pc_plus1, redirect_count);
    end
    step();
    tests_run++;
    if (pc !== 32'h1 || id_valid !== 1'b1 || id_instr !== 32'h11) begin
      tests_failed++;
      $display("FAIL first_fetch_after_reset: pc=%h valid=%b instr=%h, want 1/1/11",
               pc, id_valid, id_instr);
    end
  endtask

  task automatic test_wrap();
    reset = 1'b1;
    step();
    reset = 1'b0;
    tests_run++;
    if (pc2 !== 32'hFFFF_FFFE || id_valid2 !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrap_reset_pc: pc=%h valid=%b, want fffffffe/0", pc2, id_valid2);
    end
    step();
    tests_run++;
    if (pc2 !== 32'hFFFF_FFFF || id_pc_plus1_2 !== 32'hFFFF_FFFF || id_valid2 !== 1'b1) begin
      tests_failed++;
      $display("FAIL wrap_step1: pc=%h p1=%h valid=%b, want ffffffff/ffffffff/1",
               pc2, id_pc_plus1_2, id_valid2);
    end
    step();
    tests_run++;
    if (pc2 !== 32'h0 || id_pc_plus1_2 !== 32'h0 || id_instr2 !== 32'h0 || id_valid2 !== 1'b1) begin
      tests_failed++;
      $display("FAIL wrap_step2: pc=%h p1=%h instr=%h valid=%b, want 0/0/0/1",
               pc2, id_pc_plus1_2, id_instr2, id_valid2);
    end
  endtask

  task automatic test_saturate();
    logic [15:0] exp_cnt;
    // preload the counter near its ceiling rather than spend 128k cycles
    force dut.redirect_count = 16'hFFFD;
    #1;
    release dut.redirect_count;
    exp_cnt = 16'hFFFD;
    for (int i = 0; i < 4; i++) begin
      jump = 1'b1; jump_target = 32'h10;
      step();
      jump = 1'b0;
      if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      tests_run++;
      if (redirect_count !== exp_cnt || pc !== 32'h10) begin
        tests_failed++;
        $display("FAIL saturate_%0d: cnt=%h pc=%h, want %h/10", i, redirect_count, pc, exp_cnt);
      end
      step();  // refill IF/ID so the next jump is from a valid entry
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_branch();
    test_jump();
    test_stall();
    test_reset_override();
    test_wrap();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Instruction-fetch stage of the pipeline: holds the word-addressed program counter, captures the fetched instruction into the IF/ID register, and computes the branch target from the already-shifted sign-extended offset produced in ID. PC advances by 1 per instruction (word addressing), so the offset is added unscaled. The stage sits between instruction memory and decode, and applies stall, branch and jump redirects with a one-bubble flush.

## Interface
- PC_WIDTH, 32: width of PC, targets and offsets.
- RESET_PC, 0: PC value loaded on reset.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard unit hold; freezes PC and IF/ID.
- branch_taken  in  1  ID-stage branch decision for the instruction in IF/ID.
- jump  in  1  ID-stage unconditional jump for the instruction in IF/ID.
- branch_offset  in  PC_WIDTH  shifted sign-extended immediate, in words.
- jump_target  in  PC_WIDTH  absolute jump address, in words.
- instr_in  in  32  instruction memory read data for address pc (asynchronous read).
- pc  out  PC_WIDTH  current fetch address (registered).
- id_instr  out  32  IF/ID instruction.
- id_pc_plus1  out  PC_WIDTH  IF/ID address of the next sequential instruction.
- id_valid  out  1  IF/ID holds a real instruction (0 = bubble).
- branch_target  out  PC_WIDTH  id_pc_plus1 + branch_offset (combinational).
- redirect_count  out  16  count of taken redirects, saturating.

## Operation
- Reset values: pc = RESET_PC; id_instr = 0 (NOP); id_pc_plus1 = 0; id_valid = 0; redirect_count = 0.
- Internal signal redirect = id_valid & (jump | branch_taken).
- Redirect target: jump_target when jump = 1, otherwise branch_target. Jump wins when both are set.
- branch_target = id_pc_plus1 + branch_offset, modulo 2^PC_WIDTH. The offset is never rescaled.
- Per-edge priority (highest first):
  - reset: load reset values.
  - stall: pc, id_instr, id_pc_plus1, id_valid and redirect_count all hold; branch_taken and jump are ignored (ID re-asserts them after the stall).
  - redirect: pc ← target; id_instr ← 0; id_valid ← 0; id_pc_plus1 ← 0. The instruction fetched this cycle is discarded. redirect_count increments, saturating at 0xFFFF.
  - normal: id_instr ← instr_in; id_pc_plus1 ← pc + 1; id_valid ← 1; pc ← pc + 1.
- While id_valid = 0, branch_taken and jump have no effect, so a bubble can never redirect.
- pc + 1 wraps from 2^PC_WIDTH−1 to 0 with no flag.

## Timing
- Fetch: pc is presented in cycle N, instr_in is sampled at the end of N, and the instruction appears in id_instr in cycle N+1.
- Branch or jump resolved in ID in cycle N: pc = target in N+1, id_valid = 0 in N+1 (exactly one bubble), and the target instruction reaches id_instr in N+2.
- Stall asserted in cycles N..N+k−1: outputs are frozen through N+k−1, and normal advance resumes at the edge ending N+k.
- Reset mid-operation overrides stall and redirect on the same edge. The first fetch after reset is from RESET_PC, and id_valid goes to 1 one cycle after reset deasserts.
- branch_target and pc are glitch-free with respect to redirect. Only registered state feeds pc.

## Test plan
- Reset, then 4 free-running cycles with instr_in = 0x11,0x22,0x33,0x44 → pc = 0,1,2,3,4; id_instr lags by one cycle; id_pc_plus1 = 1,2,3,4; id_valid = 1 from the second cycle.
- id_pc_plus1 = 5 with branch_offset = 0xFFFFFFFD and branch_taken = 1 → branch_target = 2; next cycle pc = 2, id_valid = 0, redirect_count = 1; following cycle id_instr = mem[2].
- jump = 1 and branch_taken = 1 together, jump_target = 0x40 → pc = 0x40 (jump wins); branch_taken with id_valid = 0 → no redirect, count unchanged.
- stall held 3 cycles while branch_taken = 1 → pc, IF/ID and redirect_count unchanged for 3 cycles; redirect occurs on the first unstalled edge.
- RESET_PC = 0xFFFFFFFE, 3 free-running cycles → pc = 0xFFFFFFFE, 0xFFFFFFFF, 0x0; id_pc_plus1 wraps to 0. Force 0x10000 redirects → redirect_count saturates at 0xFFFF.
- reset asserted in the same cycle as a redirect and a stall → reset values on the next edge; pc = RESET_PC.
